// File: rtl/ballot_collector.sv
// ballot_collector: front end for a 4-input majority voter.
// Opens a voting round on start and collects one ballot per voter over a
// valid/ack handshake. The round closes when all four ballots are in or
// when the round timer expires. The latched votes A..D are then presented
// together with a one-cycle votes_valid strobe. Voters that never voted read 0.
module ballot_collector #(
    parameter int TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [3:0] ballot_valid,
    input  logic [3:0] ballot_val,
    output logic [3:0] ballot_ack,
    output logic       busy,
    output logic       A,
    output logic       B,
    output logic       C,
    output logic       D,
    output logic [3:0] voted,
    output logic       votes_valid,
    output logic       timed_out
);

    localparam int            TW     = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] W_LAST = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_COLLECT,
        S_DONE
    } state_t;

    state_t        r_state;
    state_t        w_next;
    logic [TW-1:0] r_timer;
    logic [3:0]    r_votes;
    logic [3:0]    r_voted;
    logic [3:0]    r_ack;
    logic          r_timed_out;

    logic [3:0]    w_accept;
    logic [3:0]    w_voted_next;
    logic          w_all;
    logic          w_last;

    // Ballots accepted this edge: valid, not yet voted, and only while collecting.
    // NOTE: every signal gets a default at the top of an always_comb, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        w_accept = 4'b0000;
        if (r_state == S_COLLECT) begin
            w_accept = ballot_valid & ~r_voted;
        end
        w_voted_next = r_voted | w_accept;
        w_all        = &w_voted_next;
        w_last       = (r_timer == W_LAST);
    end

    // State register.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic and state-decoded outputs. Completion outranks timeout.
    always_comb begin
        w_next      = r_state;
        busy        = 1'b0;
        votes_valid = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next = S_COLLECT;
                end
            end
            S_COLLECT: begin
                busy = 1'b1;
                if (w_all || w_last) begin
                    w_next = S_DONE;
                end
            end
            S_DONE: begin
                busy        = 1'b1;
                votes_valid = 1'b1;
                w_next      = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Round datapath: clear on round open, latch first ballot per voter,
    // count COLLECT cycles, and hold results from DONE until the next open.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_timer     <= '0;
            r_votes     <= 4'b0000;
            r_voted     <= 4'b0000;
            r_ack       <= 4'b0000;
            r_timed_out <= 1'b0;
        end else begin
            r_ack <= 4'b0000;
            unique case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_timer     <= '0;
                        r_votes     <= 4'b0000;
                        r_voted     <= 4'b0000;
                        r_timed_out <= 1'b0;
                    end
                end
                S_COLLECT: begin
                    r_ack   <= w_accept;
                    r_votes <= (r_votes & ~w_accept) | (ballot_val & w_accept);
                    r_voted <= w_voted_next;
                    r_timer <= r_timer + 1'b1;
                    if (!w_all && w_last) begin
                        r_timed_out <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign ballot_ack = r_ack;
    assign voted      = r_voted;
    assign timed_out  = r_timed_out;
    assign A          = r_votes[0];
    assign B          = r_votes[1];
    assign C          = r_votes[2];
    assign D          = r_votes[3];

endmodule

// File: tb/tb_ballot_collector.sv
// Self-checking bench for ballot_collector. A TIMEOUT=16 instance runs the
// main sequence. A TIMEOUT=4 instance shares the ballot inputs, but it only
// opens a round on its own start, so it can exercise the last-cycle race.
// Expected round results go into a queue when the ballots are driven.
// A monitor pops and compares each entry on every votes_valid strobe.
module tb_ballot_collector;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       start4;
    logic [3:0] ballot_valid;
    logic [3:0] ballot_val;

    logic [3:0] ack16, voted16;
    logic       busy16, a16, b16, c16, d16, vv16, to16;
    logic [3:0] ack4, voted4;
    logic       busy4, a4, b4, c4, d4, vv4, to4;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic [3:0] votes;
        logic [3:0] voted;
        logic       to;
    } exp_t;

    exp_t q16[$];
    exp_t q4[$];

    always #5 clk = ~clk;

    ballot_collector #(.TIMEOUT(16)) dut16 (
        .clk(clk), .rst(rst), .start(start),
        .ballot_valid(ballot_valid), .ballot_val(ballot_val),
        .ballot_ack(ack16), .busy(busy16),
        .A(a16), .B(b16), .C(c16), .D(d16),
        .voted(voted16), .votes_valid(vv16), .timed_out(to16)
    );

    ballot_collector #(.TIMEOUT(4)) dut4 (
        .clk(clk), .rst(rst), .start(start4),
        .ballot_valid(ballot_valid), .ballot_val(ballot_val),
        .ballot_ack(ack4), .busy(busy4),
        .A(a4), .B(b4), .C(c4), .D(d4),
        .voted(voted4), .votes_valid(vv4), .timed_out(to4)
    );

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic maj(input logic [3:0] v);
        int s;
        s = int'(v[0]) + int'(v[1]) + int'(v[2]) + int'(v[3]);
        return (s >= 3);
    endfunction

    // Scoreboard monitor: every votes_valid strobe must match the oldest expectation.
    always @(negedge clk) begin
        exp_t e;
        if (vv16 === 1'b1) begin
            if (q16.size() == 0) begin
                check("sb16.unexpected_strobe", 16'd1, 16'd0);
            end else begin
                e = q16.pop_front();
                check("sb16.votes", {12'd0, d16, c16, b16, a16}, {12'd0, e.votes});
                check("sb16.voted", {12'd0, voted16}, {12'd0, e.voted});
                check("sb16.timed_out", {15'd0, to16}, {15'd0, e.to});
            end
        end
        if (vv4 === 1'b1) begin
            if (q4.size() == 0) begin
                check("sb4.unexpected_strobe", 16'd1, 16'd0);
            end else begin
                e = q4.pop_front();
                check("sb4.votes", {12'd0, d4, c4, b4, a4}, {12'd0, e.votes});
                check("sb4.voted", {12'd0, voted4}, {12'd0, e.voted});
                check("sb4.timed_out", {15'd0, to4}, {15'd0, e.to});
            end
        end
    end

    initial begin
        rst          = 1'b1;
        start        = 1'b0;
        start4       = 1'b0;
        ballot_valid = 4'b0000;
        ballot_val   = 4'b0000;
        tick();
        tick();

        // Reset state.
        check("rst.busy", {15'd0, busy16}, 16'd0);
        check("rst.vv", {15'd0, vv16}, 16'd0);
        check("rst.outs", {4'd0, voted16, ack16, d16, c16, b16, a16, to16, 3'd0}, 16'd0);
        rst = 1'b0;

        // Reset mid-round: two ballots accepted, then rst aborts the round.
        start = 1'b1;
        tick();
        start = 1'b0;
        check("mid.busy_open", {15'd0, busy16}, 16'd1);
        ballot_valid = 4'b0011;
        ballot_val   = 4'b0011;
        tick();
        ballot_valid = 4'b0000;
        check("mid.ack", {12'd0, ack16}, 16'h0003);
        check("mid.voted", {12'd0, voted16}, 16'h0003);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid.after_rst", {4'd0, voted16, ack16, d16, c16, b16, a16, to16, busy16, vv16, 1'b0}, 16'd0);
        tick();
        check("mid.no_strobe", {15'd0, vv16}, 16'd0);

        // Full round on a single edge.
        start = 1'b1;
        tick();
        start        = 1'b0;
        ballot_valid = 4'b1111;
        ballot_val   = 4'b0111;
        q16.push_back('{votes: 4'b0111, voted: 4'b1111, to: 1'b0});
        tick();
        ballot_valid = 4'b0000;
        check("full.ack", {12'd0, ack16}, 16'h000f);
        check("full.vv", {15'd0, vv16}, 16'd1);
        check("full.y", {15'd0, maj({d16, c16, b16, a16})}, 16'd1);
        tick();
        check("full.vv_drop", {15'd0, vv16}, 16'd0);
        check("full.ack_drop", {12'd0, ack16}, 16'd0);
        check("full.idle", {15'd0, busy16}, 16'd0);
        check("full.hold", {12'd0, d16, c16, b16, a16}, 16'h0007);

        // Staggered ballots with a duplicate from voter 2.
        start = 1'b1;
        tick();                                  // COLLECT cycle 0
        start        = 1'b0;
        ballot_valid = 4'b0100;
        ballot_val   = 4'b0100;
        tick();                                  // cycle 1
        ballot_valid = 4'b0000;
        check("stag.ack_c", {12'd0, ack16}, 16'h0004);
        tick();                                  // cycle 2
        tick();                                  // cycle 3
        ballot_valid = 4'b0100;
        ballot_val   = 4'b0000;
        tick();                                  // cycle 4
        ballot_valid = 4'b0000;
        check("stag.dup_noack", {12'd0, ack16}, 16'd0);
        check("stag.dup_keep", {15'd0, c16}, 16'd1);
        tick();                                  // cycle 5
        ballot_valid = 4'b0001;
        tick();                                  // cycle 6
        check("stag.ack_a", {12'd0, ack16}, 16'h0001);
        ballot_valid = 4'b0010;
        tick();                                  // cycle 7
        check("stag.ack_b", {12'd0, ack16}, 16'h0002);
        ballot_valid = 4'b1000;
        q16.push_back('{votes: 4'b0100, voted: 4'b1111, to: 1'b0});
        tick();                                  // cycle 8: DONE
        ballot_valid = 4'b0000;
        check("stag.vv", {15'd0, vv16}, 16'd1);
        check("stag.ack_d", {12'd0, ack16}, 16'h0008);
        tick();

        // Timeout with only voters 0 and 1.
        start = 1'b1;
        tick();                                  // cycle 0
        start        = 1'b0;
        ballot_valid = 4'b0011;
        ballot_val   = 4'b0011;
        q16.push_back('{votes: 4'b0011, voted: 4'b0011, to: 1'b1});
        tick();                                  // cycle 1
        ballot_valid = 4'b0000;
        check("to.ack", {12'd0, ack16}, 16'h0003);
        for (int i = 1; i < 16; i++) begin
            check("to.no_early_vv", {15'd0, vv16}, 16'd0);
            check("to.busy", {15'd0, busy16}, 16'd1);
            tick();
        end
        check("to.vv_at16", {15'd0, vv16}, 16'd1);
        check("to.timed_out", {15'd0, to16}, 16'd1);
        tick();
        check("to.held", {15'd0, to16}, 16'd1);

        // Ballots in IDLE are ignored.
        ballot_valid = 4'b1111;
        ballot_val   = 4'b1111;
        tick();
        ballot_valid = 4'b0000;
        tick();
        check("idle.noack", {12'd0, ack16}, 16'd0);
        check("idle.voted_held", {12'd0, voted16}, 16'h0003);

        // Last-cycle race on the TIMEOUT=4 instance: completion wins.
        start4 = 1'b1;
        tick();                                  // dut4 cycle 0
        start4       = 1'b0;
        ballot_valid = 4'b0111;
        ballot_val   = 4'b0101;
        tick();                                  // cycle 1
        ballot_valid = 4'b0000;
        check("race.busy", {15'd0, busy4}, 16'd1);
        check("race.idle16_noack", {12'd0, ack16}, 16'd0);
        tick();                                  // cycle 2
        tick();                                  // cycle 3, timer at its last value
        ballot_valid = 4'b1000;
        ballot_val   = 4'b1000;
        q4.push_back('{votes: 4'b1101, voted: 4'b1111, to: 1'b0});
        tick();                                  // DONE
        ballot_valid = 4'b0000;
        check("race.vv", {15'd0, vv4}, 16'd1);
        check("race.ack_d", {12'd0, ack4}, 16'h0008);
        check("race.timed_out", {15'd0, to4}, 16'd0);
        tick();

        // Start held high: ignored in COLLECT and DONE, honoured in IDLE.
        start = 1'b1;
        tick();                                  // COLLECT
        ballot_valid = 4'b1111;
        ballot_val   = 4'b1010;
        q16.push_back('{votes: 4'b1010, voted: 4'b1111, to: 1'b0});
        tick();                                  // DONE
        ballot_valid = 4'b0000;
        check("b2b.vv", {15'd0, vv16}, 16'd1);
        tick();                                  // IDLE despite start
        check("b2b.idle", {15'd0, busy16}, 16'd0);
        check("b2b.hold", {12'd0, d16, c16, b16, a16}, 16'h000a);
        check("b2b.hold_voted", {12'd0, voted16}, 16'h000f);
        tick();                                  // reopened
        check("b2b.reopen", {15'd0, busy16}, 16'd1);
        check("b2b.cleared", {11'd0, d16, c16, b16, a16, to16}, 16'd0);
        check("b2b.voted_clr", {12'd0, voted16}, 16'd0);
        start = 1'b0;
        rst   = 1'b1;
        tick();
        rst = 1'b0;
        tick();

        check("sb.drained16", 16'(q16.size()), 16'd0);
        check("sb.drained4", 16'(q4.size()), 16'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
